// File: rtl/gpu_regs_pkg.sv
// gpu_regs_pkg: register map offsets, control/status bit positions and byte-merge helper
package gpu_regs_pkg;
    localparam int CTRL_START  = 0;
    localparam int CTRL_IRQ_EN = 1;
    localparam int STAT_BUSY   = 0;
    localparam int STAT_DONE   = 1;
    localparam int STAT_ERR    = 2;

    typedef enum logic {IDLE, BUSY} draw_state_t;

    function automatic int addr_vertex(input int n);
        return 0 * n;
    endfunction

    function automatic int addr_colour(input int n);
        return n;
    endfunction

    function automatic int addr_back(input int n);
        return 2 * n;
    endfunction

    function automatic int addr_ctrl(input int n);
        return 2 * n + 1;
    endfunction

    function automatic int addr_status(input int n);
        return 2 * n + 2;
    endfunction

    function automatic int addr_win(input int n);
        return 2 * n + 3;
    endfunction

    function automatic logic [7:0] byte_merge(input logic [7:0] cur, input logic [7:0] wr, input logic en);
        return en ? wr : cur;
    endfunction
endpackage

// File: rtl/gpu_shadow_reg.sv
// gpu_shadow_reg: one byte-writable shadow register with an active copy loaded on commit
module gpu_shadow_reg
    import gpu_regs_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                we,
    input  logic                commit,
    input  logic [DATA_W/8-1:0] be,
    input  logic [DATA_W-1:0]   wdata,
    output logic [DATA_W-1:0]   shadow,
    output logic [DATA_W-1:0]   active
);
    logic [DATA_W-1:0] merged;

    // next shadow value with only the enabled bytes replaced
    always_comb begin
        merged = shadow;
        for (int k = 0; k < DATA_W / 8; k++)
            merged[k*8 +: 8] = byte_merge(shadow[k*8 +: 8], wdata[k*8 +: 8], be[k]);
    end

    // active copies the pre-edge shadow, so a same-edge shadow write never leaks into a commit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (we) shadow <= merged;
            if (commit) active <= shadow;
        end
    end
endmodule

// File: rtl/gpu_register_bank.sv
// gpu_register_bank: double-buffered Avalon-MM triangle registers with draw handshake and IRQ
module gpu_register_bank
    import gpu_regs_pkg::*;
#(
    parameter int DATA_W    = 64,
    parameter int NUM_VERTS = 3,
    parameter int ADDR_W    = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [ADDR_W-1:0]             address,
    input  logic                          write,
    input  logic                          read,
    input  logic [DATA_W-1:0]             writedata,
    input  logic [DATA_W/8-1:0]           byteenable,
    output logic [DATA_W-1:0]             readdata,
    output logic                          readdatavalid,
    input  logic                          raster_done,
    output logic                          draw_start,
    output logic                          busy,
    output logic                          irq,
    output logic [NUM_VERTS*DATA_W-1:0]   vertex_out,
    output logic [NUM_VERTS*DATA_W-1:0]   colour_out,
    output logic [DATA_W-1:0]             back_colour_out,
    output logic [DATA_W-1:0]             win_size_out
);
    localparam int NS = 2 * NUM_VERTS;
    localparam logic [ADDR_W-1:0] A_BACK = ADDR_W'(addr_back(NUM_VERTS));
    localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(addr_ctrl(NUM_VERTS));
    localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(addr_status(NUM_VERTS));
    localparam logic [ADDR_W-1:0] A_WIN  = ADDR_W'(addr_win(NUM_VERTS));

    draw_state_t       state, state_nxt;
    logic [DATA_W-1:0] shadow [NS];
    logic [DATA_W-1:0] active [NS];
    logic [DATA_W-1:0] rd_mux;
    logic              done, err, irq_en;
    logic              ctrl_wr, stat_wr, start_req, start_ok, done_set, err_set;

    function automatic logic [DATA_W-1:0] masked(input logic [DATA_W-1:0] cur);
        logic [DATA_W-1:0] r;
        for (int k = 0; k < DATA_W / 8; k++)
            r[k*8 +: 8] = byte_merge(cur[k*8 +: 8], writedata[k*8 +: 8], byteenable[k]);
        return r;
    endfunction

    assign ctrl_wr   = write && address == A_CTRL && byteenable[0];
    assign stat_wr   = write && address == A_STAT && byteenable[0];
    assign start_req = ctrl_wr && writedata[CTRL_START];
    assign start_ok  = start_req && (state == IDLE || raster_done);
    assign done_set  = raster_done && state == BUSY;
    assign err_set   = start_req && !start_ok;
    assign busy      = state == BUSY;

    for (genvar g = 0; g < NS; g++) begin : g_reg
        gpu_shadow_reg #(.DATA_W(DATA_W)) u_reg (
            .clk    (clk),
            .reset  (reset),
            .we     (write && address == ADDR_W'(g)),
            .commit (start_ok),
            .be     (byteenable),
            .wdata  (writedata),
            .shadow (shadow[g]),
            .active (active[g])
        );
        if (g < NUM_VERTS) begin : g_v
            assign vertex_out[g*DATA_W +: DATA_W] = active[g];
        end else begin : g_c
            assign colour_out[(g-NUM_VERTS)*DATA_W +: DATA_W] = active[g];
        end
    end

    // a same-cycle accepted START keeps the draw running even when raster_done ends the old one
    always_comb begin
        state_nxt = start_ok ? BUSY : done_set ? IDLE : state;
    end

    // draw state, start pulse, sticky flags (hardware set beats W1C) and registered irq
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            draw_start <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            irq_en     <= 1'b0;
            irq        <= 1'b0;
        end else begin
            state      <= state_nxt;
            draw_start <= start_ok;
            done       <= done_set || (done && !(stat_wr && writedata[STAT_DONE]));
            err        <= err_set || (err && !(stat_wr && writedata[STAT_ERR]));
            irq_en     <= ctrl_wr ? writedata[CTRL_IRQ_EN] : irq_en;
            irq        <= done && irq_en;
        end
    end

    // background colour and window size drive their outputs directly
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            back_colour_out <= '0;
            win_size_out    <= '0;
        end else begin
            if (write && address == A_BACK) back_colour_out <= masked(back_colour_out);
            if (write && address == A_WIN) win_size_out <= masked(win_size_out);
        end
    end

    // read mux sees pre-edge values, so a simultaneous write is not visible to the read
    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NS; i++)
            if (address == ADDR_W'(i)) rd_mux = shadow[i];
        if (address == A_BACK) rd_mux = back_colour_out;
        if (address == A_CTRL) rd_mux = DATA_W'({irq_en, 1'b0});
        if (address == A_STAT) rd_mux = DATA_W'({err, done, busy});
        if (address == A_WIN) rd_mux = win_size_out;
    end

    // one-cycle read latency; readdata holds between reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            readdata      <= '0;
            readdatavalid <= 1'b0;
        end else begin
            readdatavalid <= read;
            if (read) readdata <= rd_mux;
        end
    end
endmodule

// File: tb/tb_gpu_register_bank.sv
// tb_gpu_register_bank: randomized scoreboard bench with a behavioural register-bank model
module tb_gpu_register_bank;
    localparam int DW = 64;
    localparam int NV = 3;
    localparam int AW = 4;
    localparam int NB = DW / 8;
    localparam int W  = NV * DW;
    localparam int A_BACK = 2 * NV;
    localparam int A_CTRL = 2 * NV + 1;
    localparam int A_STAT = 2 * NV + 2;
    localparam int A_WIN  = 2 * NV + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          write = 1'b0;
    logic          read = 1'b0;
    logic          raster_done = 1'b0;
    logic [AW-1:0] address = '0;
    logic [DW-1:0] writedata = '0;
    logic [NB-1:0] byteenable = '0;
    logic [DW-1:0] readdata, back_colour_out, win_size_out;
    logic          readdatavalid, draw_start, busy, irq;
    logic [W-1:0]  vertex_out, colour_out;

    int checks = 0;
    int failures = 0;
    logic [DW-1:0] exp_q[$];

    logic [DW-1:0] m_sh [2*NV];
    logic [DW-1:0] m_act [2*NV];
    logic [DW-1:0] m_back, m_win, m_rdata;
    bit m_busy, m_done, m_err, m_irq_en, m_irq, m_ds, m_rdv;

    always #5 clk = ~clk;

    gpu_register_bank #(.DATA_W(DW), .NUM_VERTS(NV), .ADDR_W(AW)) dut (
        .clk             (clk),
        .reset           (reset),
        .address         (address),
        .write           (write),
        .read            (read),
        .writedata       (writedata),
        .byteenable      (byteenable),
        .readdata        (readdata),
        .readdatavalid   (readdatavalid),
        .raster_done     (raster_done),
        .draw_start      (draw_start),
        .busy            (busy),
        .irq             (irq),
        .vertex_out      (vertex_out),
        .colour_out      (colour_out),
        .back_colour_out (back_colour_out),
        .win_size_out    (win_size_out)
    );

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor: every readdatavalid must match the oldest outstanding read
    always @(negedge clk) begin
        if (!reset && readdatavalid) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL rdv_spurious: got readdatavalid=1 expected no read outstanding");
            end else begin
                chk("sb_readdata", W'(readdata), W'(exp_q.pop_front()));
            end
        end
    end

    function automatic logic [DW-1:0] merge(input logic [DW-1:0] cur, input logic [DW-1:0] wd, input logic [NB-1:0] be);
        logic [DW-1:0] r = cur;
        for (int k = 0; k < NB; k++)
            if (be[k]) r[k*8 +: 8] = wd[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [DW-1:0] m_read(input int a);
        if (a < 2 * NV) return m_sh[a];
        if (a == A_BACK) return m_back;
        if (a == A_CTRL) return DW'({m_irq_en, 1'b0});
        if (a == A_STAT) return DW'({m_err, m_done, m_busy});
        if (a == A_WIN) return m_win;
        return '0;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2 * NV; i++) begin
            m_sh[i] = '0;
            m_act[i] = '0;
        end
        m_back = '0; m_win = '0; m_rdata = '0;
        m_busy = 0; m_done = 0; m_err = 0; m_irq_en = 0; m_irq = 0; m_ds = 0; m_rdv = 0;
        exp_q.delete();
    endtask

    task automatic check_outs();
        logic [W-1:0] ev, ec;
        for (int i = 0; i < NV; i++) begin
            ev[i*DW +: DW] = m_act[i];
            ec[i*DW +: DW] = m_act[NV+i];
        end
        chk("draw_start", W'(draw_start), W'(m_ds));
        chk("busy", W'(busy), W'(m_busy));
        chk("irq", W'(irq), W'(m_irq));
        chk("readdatavalid", W'(readdatavalid), W'(m_rdv));
        chk("readdata_hold", W'(readdata), W'(m_rdata));
        chk("vertex_out", vertex_out, ev);
        chk("colour_out", colour_out, ec);
        chk("back_colour", W'(back_colour_out), W'(m_back));
        chk("win_size", W'(win_size_out), W'(m_win));
    endtask

    // one bus cycle: drive, advance the model by one edge, then compare all outputs
    task automatic cyc(input bit wr, input bit rd, input int a, input logic [DW-1:0] wd,
                       input logic [NB-1:0] be, input bit rdn);
        bit start_req, start_ok, done_set;
        write = wr; read = rd; address = AW'(a); writedata = wd; byteenable = be; raster_done = rdn;
        if (rd) begin
            exp_q.push_back(m_read(a));
            m_rdata = m_read(a);
        end
        m_rdv = rd;
        start_req = wr && a == A_CTRL && be[0] && wd[0];
        start_ok = start_req && (!m_busy || rdn);
        done_set = rdn && m_busy;
        m_irq = m_done && m_irq_en;
        if (start_ok)
            for (int i = 0; i < 2 * NV; i++) m_act[i] = m_sh[i];
        if (wr && a < 2 * NV) m_sh[a] = merge(m_sh[a], wd, be);
        if (wr && a == A_BACK) m_back = merge(m_back, wd, be);
        if (wr && a == A_WIN) m_win = merge(m_win, wd, be);
        if (wr && a == A_STAT && be[0]) begin
            if (wd[1]) m_done = 0;
            if (wd[2]) m_err = 0;
        end
        if (done_set) m_done = 1;
        if (start_req && !start_ok) m_err = 1;
        if (wr && a == A_CTRL && be[0]) m_irq_en = wd[1];
        m_busy = start_ok ? 1'b1 : done_set ? 1'b0 : m_busy;
        m_ds = start_ok;
        @(posedge clk);
        #1;
        write = 0; read = 0; raster_done = 0;
        check_outs();
    endtask

    initial begin
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outs();
        reset = 0;

        cyc(1, 0, 0, 64'h0000_0010_0000_0020, 8'hFF, 0);
        cyc(1, 0, A_CTRL, 64'h1, 8'h01, 0);
        chk("v0_commit", W'(vertex_out[63:0]), W'(64'h0000_0010_0000_0020));
        chk("start_pulse", W'(draw_start), W'(1'b1));
        cyc(0, 1, A_STAT, 64'h0, 8'h00, 0);
        chk("status_busy", W'(readdata), W'(64'h1));
        cyc(1, 0, 1, 64'h55, 8'hFF, 0);
        cyc(0, 1, 1, 64'h0, 8'h00, 0);
        chk("v1_shadow", W'(readdata), W'(64'h55));
        chk("v1_active", W'(vertex_out[127:64]), W'(64'h0));
        cyc(1, 0, A_CTRL, 64'h1, 8'h01, 0);
        chk("reject_no_pulse", W'(draw_start), W'(1'b0));
        cyc(0, 1, A_STAT, 64'h0, 8'h00, 0);
        chk("status_err", W'(readdata), W'(64'h5));
        cyc(1, 0, A_CTRL, 64'h2, 8'h01, 0);
        cyc(1, 0, A_STAT, 64'h4, 8'h01, 0);
        cyc(0, 0, 0, 64'h0, 8'h00, 1);
        cyc(0, 1, A_STAT, 64'h0, 8'h00, 0);
        chk("status_done", W'(readdata), W'(64'h2));
        chk("irq_set", W'(irq), W'(1'b1));
        cyc(1, 0, A_STAT, 64'h2, 8'h01, 0);
        cyc(0, 0, 0, 64'h0, 8'h00, 0);
        chk("irq_clear", W'(irq), W'(1'b0));
        cyc(1, 0, A_CTRL, 64'h3, 8'h01, 0);
        cyc(1, 0, A_CTRL, 64'h3, 8'h01, 1);
        chk("restart_pulse", W'(draw_start), W'(1'b1));
        chk("restart_busy", W'(busy), W'(1'b1));
        cyc(0, 1, A_STAT, 64'h0, 8'h00, 0);
        chk("status_restart", W'(readdata), W'(64'h3));
        cyc(1, 0, A_WIN, 64'hFFFF_FFFF_FFFF_FFFF, 8'h0F, 0);
        cyc(0, 1, A_WIN, 64'h0, 8'h00, 0);
        chk("win_partial", W'(readdata), W'(64'h0000_0000_FFFF_FFFF));
        cyc(0, 1, 15, 64'h0, 8'h00, 0);
        chk("unmapped_rd", W'(readdata), W'(64'h0));
        cyc(1, 1, 2, 64'hAB, 8'hFF, 0);
        chk("rd_before_wr", W'(readdata), W'(64'h0));
        cyc(0, 0, 0, 64'h0, 8'h00, 0);

        #3 reset = 1;
        #1;
        m_reset();
        check_outs();
        @(posedge clk);
        #1 reset = 0;
        cyc(0, 0, 0, 64'h0, 8'h00, 1);
        cyc(0, 1, A_STAT, 64'h0, 8'h00, 0);
        chk("status_after_reset", W'(readdata), W'(64'h0));

        for (int n = 0; n < 400; n++) begin
            int a = $urandom_range(0, 15);
            if ($urandom_range(0, 4) == 0) a = A_CTRL;
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), a, {$urandom, $urandom},
                NB'($urandom), $urandom_range(0, 4) == 0);
        end

        cyc(0, 0, 0, 64'h0, 8'h00, 0);
        cyc(0, 0, 0, 64'h0, 8'h00, 0);
        chk("sb_drain", W'(exp_q.size()), W'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
